// File: rtl/centroid_calc.sv
`default_nettype none
// ============================================================================
//  Module      : centroid_calc
//  Description : Computes the centroid of a binary segmentation mask once per
//                video frame. Coordinate sums and the pixel count of mask
//                pixels are accumulated during the active frame. At the rising
//                edge of vsync they are snapshotted into two parallel radix-2
//                restoring dividers, and the floor quotients are published
//                33 clock edges later.
//  Ports       : clk            - pixel clock, rising edge
//                rst            - asynchronous active-high reset
//                de             - data enable, one active pixel per cycle
//                hsync          - horizontal sync, timing alignment only
//                vsync          - vertical sync, high between frames
//                mask           - 1 = pixel belongs to the object
//                x_center       - floor(sum_x / count)
//                y_center       - floor(sum_y / count)
//                centroid_valid - one-cycle pulse when results update
//                detected       - last completed frame had count > 0
//  Revision    : 1.0 - initial release
// ============================================================================
module centroid_calc #(
    parameter int IMG_H = 720,
    parameter int IMG_W = 1280
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        mask,
    output logic [31:0] x_center,
    output logic [31:0] y_center,
    output logic        centroid_valid,
    output logic        detected
);

    localparam logic [10:0] c_X_LAST = 11'(IMG_W - 1);
    localparam logic [9:0]  c_Y_LAST = 10'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vsync_d;
    logic [10:0] r_x_pos;
    logic [9:0]  r_y_pos;
    logic [31:0] r_sum_x;
    logic [31:0] r_sum_y;
    logic [31:0] r_count;

    logic [31:0] r_dvd_x;
    logic [31:0] r_dvd_y;
    logic [31:0] r_dvs;
    logic [31:0] r_rem_x;
    logic [31:0] r_rem_y;
    logic [31:0] r_q_x;
    logic [31:0] r_q_y;
    logic [4:0]  r_bit;

    logic        w_frame_end;
    logic        w_pix_hit;
    logic [32:0] w_step_x;
    logic [32:0] w_step_y;
    logic        w_unused_hsync;

    assign w_unused_hsync = hsync;

    assign w_frame_end = vsync & ~r_vsync_d;
    assign w_pix_hit   = de & mask & ~vsync;

    // One restoring-division step: returns {quotient_bit, next_remainder}.
    // The remainder is always below the divisor, so the shifted trial value
    // fits 33 bits and the result fits back into 32. A zero divisor yields
    // an all-ones quotient with defined values; that quotient is discarded.
    function automatic logic [32:0] f_div_step(
        input logic [31:0] rem,
        input logic        dbit,
        input logic [31:0] dvs
    );
        logic [32:0] trial;
        logic [32:0] diff;
        trial = {rem, dbit};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            f_div_step = {1'b1, diff[31:0]};
        end else begin
            f_div_step = {1'b0, trial[31:0]};
        end
    endfunction

    assign w_step_x = f_div_step(r_rem_x, r_dvd_x[r_bit], r_dvs);
    assign w_step_y = f_div_step(r_rem_y, r_dvd_y[r_bit], r_dvs);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_frame_end) w_state_nxt = S_DIV;
            S_DIV:   if (r_bit == 5'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel position and accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_x_pos   <= '0;
            r_y_pos   <= '0;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_count   <= '0;
        end else begin
            r_vsync_d <= vsync;

            if (vsync) begin
                r_x_pos <= '0;
                r_y_pos <= '0;
            end else if (de) begin
                if (r_x_pos == c_X_LAST) begin
                    r_x_pos <= '0;
                    r_y_pos <= (r_y_pos == c_Y_LAST) ? 10'd0 : r_y_pos + 10'd1;
                end else begin
                    r_x_pos <= r_x_pos + 11'd1;
                end
            end

            // Accumulators clear at every frame end, whether or not the
            // divider was free to take the snapshot.
            if (w_frame_end) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_count <= '0;
            end else if (w_pix_hit) begin
                r_sum_x <= r_sum_x + {21'd0, r_x_pos};
                r_sum_y <= r_sum_y + {22'd0, r_y_pos};
                r_count <= r_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dividers and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd_x        <= '0;
            r_dvd_y        <= '0;
            r_dvs          <= '0;
            r_rem_x        <= '0;
            r_rem_y        <= '0;
            r_q_x          <= '0;
            r_q_y          <= '0;
            r_bit          <= '0;
            x_center       <= '0;
            y_center       <= '0;
            centroid_valid <= 1'b0;
            detected       <= 1'b0;
        end else begin
            centroid_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_frame_end) begin
                        r_dvd_x <= r_sum_x;
                        r_dvd_y <= r_sum_y;
                        r_dvs   <= r_count;
                        r_rem_x <= '0;
                        r_rem_y <= '0;
                        r_q_x   <= '0;
                        r_q_y   <= '0;
                        r_bit   <= 5'd31;
                    end
                end
                S_DIV: begin
                    // Quotient bits arrive MSB first and shift in from the LSB.
                    r_rem_x <= w_step_x[31:0];
                    r_rem_y <= w_step_y[31:0];
                    r_q_x   <= {r_q_x[30:0], w_step_x[32]};
                    r_q_y   <= {r_q_y[30:0], w_step_y[32]};
                    r_bit   <= r_bit - 5'd1;
                end
                S_DONE: begin
                    centroid_valid <= 1'b1;
                    if (r_dvs != 32'd0) begin
                        x_center <= r_q_x;
                        y_center <= r_q_y;
                        detected <= 1'b1;
                    end else begin
                        detected <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_centroid_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_centroid_calc
//  Description : Scoreboard testbench for centroid_calc on a reduced 64x36
//                frame. Each frame end pushes hand-computed centroid values
//                and the frame-end edge index; a monitor pops and compares on
//                every centroid_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_centroid_calc;

    localparam int W = 64;
    localparam int H = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        mask;
    logic [31:0] x_center;
    logic [31:0] y_center;
    logic        centroid_valid;
    logic        detected;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        d;
        longint      e;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    logic        prev_valid = 1'b0;
    logic [31:0] last_x     = '0;
    logic [31:0] last_y     = '0;
    logic        last_d     = 1'b0;

    centroid_calc #(.IMG_H(H), .IMG_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync),
        .mask           (mask),
        .x_center       (x_center),
        .y_center       (y_center),
        .centroid_valid (centroid_valid),
        .detected       (detected)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per valid pulse; between pulses the
    // published outputs must not move.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (centroid_valid) begin
                chk("pulse_width_prev_valid", {31'd0, prev_valid}, 32'd0);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got pulse expected none at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("x_center", x_center, e.x);
                    chk("y_center", y_center, e.y);
                    chk("detected", {31'd0, detected}, {31'd0, e.d});
                    chk("latency", 32'(cyc - e.e), 32'd33);
                end
            end else begin
                chk("stable_x", x_center, last_x);
                chk("stable_y", y_center, last_y);
                chk("stable_det", {31'd0, detected}, {31'd0, last_d});
            end
        end
        prev_valid = centroid_valid;
        last_x     = x_center;
        last_y     = y_center;
        last_d     = detected;
    end

    function automatic logic pix(input int pat, input int x, input int y);
        case (pat)
            1:       pix = (x == 10 && y == 5);
            2:       pix = (x >= 20 && x <= 21 && y >= 30 && y <= 31);
            3:       pix = 1'b1;
            4:       pix = (x == 3 && y == 7);
            5:       pix = (x == 40 && y == 20);
            6:       pix = (x == 50 && y == 30);
            default: pix = 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Active frame with a two-cycle horizontal blank after every line.
    task automatic frame(input int pat);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                de   = 1'b1;
                mask = pix(pat, x, y);
                tick();
            end
            de   = 1'b0;
            mask = 1'b0;
            tick();
            tick();
        end
    endtask

    // Raise vsync (frame-end edge is the next posedge), optionally push the
    // expectation, hold vsync for n cycles with optional de/mask activity.
    task automatic end_frame(input bit push, input int ex, input int ey,
                             input bit ed, input int n, input bit bde);
        exp_t e;
        vsync = 1'b1;
        if (push) begin
            e.x = 32'(ex);
            e.y = 32'(ey);
            e.d = ed;
            e.e = cyc + 1;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            de   = bde;
            mask = bde;
            tick();
        end
        vsync = 1'b0;
        de    = 1'b0;
        mask  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        exp_t e;
        rst   = 1'b1;
        de    = 1'b0;
        hsync = 1'b0;
        vsync = 1'b1;
        mask  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", x_center, 32'd0);
        chk("reset_y", y_center, 32'd0);
        chk("reset_valid", {31'd0, centroid_valid}, 32'd0);
        chk("reset_det", {31'd0, detected}, 32'd0);

        // Releasing reset inside vsync gives an immediate frame end with an
        // empty accumulator: a pulse with detected=0 and zero outputs.
        rst = 1'b0;
        e.x = 32'd0; e.y = 32'd0; e.d = 1'b0; e.e = cyc + 1;
        sb.push_back(e);
        repeat (40) tick();
        vsync = 1'b0;
        tick();

        // Single pixel; a short vsync gap carries three extra pixels whose
        // frame end arrives while dividing, so they must be discarded.
        frame(1);
        vsync = 1'b1;
        e.x = 32'd10; e.y = 32'd5; e.d = 1'b1; e.e = cyc + 1;
        sb.push_back(e);
        repeat (10) tick();
        vsync = 1'b0;
        de    = 1'b1;
        mask  = 1'b1;
        repeat (3) tick();
        de    = 1'b0;
        mask  = 1'b0;
        end_frame(1'b0, 0, 0, 1'b0, 40, 1'b0);

        frame(2); end_frame(1'b1, 20, 30, 1'b1, 40, 1'b0);  // floor(20.5), floor(30.5)
        frame(3); end_frame(1'b1, 31, 17, 1'b1, 40, 1'b0);  // 72576/2304, 40320/2304
        frame(1); end_frame(1'b1, 10, 5, 1'b1, 40, 1'b0);
        frame(0); end_frame(1'b1, 10, 5, 1'b0, 40, 1'b1);  // empty frame holds values; blank has de/mask=1
        frame(4); end_frame(1'b1, 3, 7, 1'b1, 40, 1'b0);

        // Reset during the divide: no pulse, outputs cleared.
        frame(5);
        vsync = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("midrst_x", x_center, 32'd0);
        chk("midrst_y", y_center, 32'd0);
        chk("midrst_det", {31'd0, detected}, 32'd0);
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        rst = 1'b0;
        repeat (45) tick();
        chk("postrst_x", x_center, 32'd0);
        chk("postrst_y", y_center, 32'd0);
        chk("postrst_det", {31'd0, detected}, 32'd0);

        frame(6); end_frame(1'b1, 50, 30, 1'b1, 40, 1'b0);

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        chk("pending_expectations", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
